// File: rtl/vram_pkg.sv
// Shared defaults and clear-engine state encoding for the frame-buffer controller.
package vram_pkg;

  localparam int ADDR_W_DEFAULT = 12;
  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/vram_dp.sv
// Simple dual-port pixel RAM: one write port, one registered read port.
module vram_dp #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // NOTE: the array has no reset branch; resetting it would turn the RAM into flops.
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // NOTE: non-blocking assignment samples the array before this edge's write lands,
  // which is what gives read-before-write on an address collision.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/vram_ctrl.sv
// Frame-buffer controller: never-stalling display read, GPU write port, and an
// optional whole-frame clear engine compiled in with VRAM_CLEAR_EN.
module vram_ctrl
  import vram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic              clr_done
);

  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

`ifdef VRAM_CLEAR_EN
  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_val, w_val_nxt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_val   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_val   <= w_val_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_val_nxt   = r_val;
    wr_ready    = 1'b0;
    clr_busy    = 1'b1;
    clr_done    = 1'b0;
    case (r_state)
      IDLE: begin
        clr_busy = 1'b0;
        wr_ready = !clr_start;
        if (clr_start) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
          w_val_nxt   = clr_value;
        end
      end
      CLEAR: begin
        // Counter parks on the last address so the fill cannot start a second pass.
        if (&r_cnt) begin
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DONE: begin
        clr_done    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_we    = (r_state == CLEAR) || (wr_valid && wr_ready);
  assign w_waddr = (r_state == CLEAR) ? r_cnt : wr_addr;
  assign w_wdata = (r_state == CLEAR) ? r_val : wr_data;
`else
  logic w_unused;

  assign w_unused = ^{clr_start, clr_value};
  assign wr_ready = 1'b1;
  assign clr_busy = 1'b0;
  assign clr_done = 1'b0;
  assign w_we     = wr_valid;
  assign w_waddr  = wr_addr;
  assign w_wdata  = wr_data;
`endif

  vram_dp #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clock    (clock),
    .reset    (reset),
    .i_we     (w_we),
    .i_wr_addr(w_waddr),
    .i_wr_data(w_wdata),
    .i_rd_addr(rd_addr),
    .o_rd_data(rd_data)
  );

endmodule

// File: tb/tb_vram_ctrl.sv
// Self-checking bench for vram_ctrl against an array-level frame-buffer model;
// clear-engine scenarios are exercised when VRAM_CLEAR_EN is defined.
module tb_vram_ctrl;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 4096;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          clr_start;
  logic [DW-1:0] clr_value;
  logic          clr_busy;
  logic          clr_done;

  vram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock    (clock),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr_start(clr_start),
    .clr_value(clr_value),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  always #5 clock = ~clock;

  // Reference frame buffer; "known" marks pixels whose content the bench has defined.
  logic [DW-1:0] model [DEPTH];
  bit            known [DEPTH];
  int            n_pass  = 0;
  int            n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fill(input int lo, input int hi, input logic [DW-1:0] v);
    for (int a = lo; a < hi; a++) begin
      model[a] = v;
      known[a] = 1'b1;
    end
  endtask

  // One idle-state cycle: read ra, optionally write wa<=wd, check the read result.
  task automatic rw(input string tag, input logic [AW-1:0] ra, input logic wv,
                    input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    logic [DW-1:0] exp;
    bit            exp_known;
    rd_addr   = ra;
    wr_valid  = wv;
    wr_addr   = wa;
    wr_data   = wd;
    clr_start = 1'b0;
    #1;
    if (wv) check("wr_ready_idle", wr_ready, 1);
    exp       = model[ra];
    exp_known = known[ra];
    tick();
    if (wv) begin
      model[wa] = wd;
      known[wa] = 1'b1;
    end
    wr_valid = 1'b0;
    if (exp_known) check(tag, rd_data, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n, done_n, done_at, rdy_bad, flag;
    logic [AW-1:0] a;

    reset     = 1'b0;
    rd_addr   = '0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    clr_start = 1'b0;
    clr_value = '0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_rd_data", rd_data, 0);
    check("rst_clr_busy", clr_busy, 0);
    check("rst_clr_done", clr_done, 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("ready_after_rst", wr_ready, 1);
    tick();

    // Basic write then read with one-cycle read latency.
    rw("wr_a5", 12'h000, 1'b1, 12'h123, 8'hA5);
    rw("rd_a5", 12'h123, 1'b0, 12'h000, 8'h00);

    // Same-address collision returns the old pixel, then the new one.
    rw("prep_200", 12'h000, 1'b1, 12'h200, 8'h77);
    rw("rbw_old", 12'h200, 1'b1, 12'h200, 8'h11);
    rw("rbw_new", 12'h200, 1'b0, 12'h000, 8'h00);

    // Randomised traffic over a small window so reads hit written pixels.
    for (int i = 0; i < 300; i++) begin
      rw("rand_rd", AW'(12'h100 + $urandom_range(0, 63)), 1'($urandom_range(0, 1)),
         AW'(12'h100 + $urandom_range(0, 63)), DW'($urandom));
    end

`ifdef VRAM_CLEAR_EN
    // Clear and GPU write collide: clear wins, write is held off.
    clr_value = 8'h3C;
    clr_start = 1'b1;
    wr_valid  = 1'b1;
    wr_addr   = 12'h055;
    wr_data   = 8'hFF;
    rd_addr   = 12'h000;
    #1;
    check("ready_vs_clr", wr_ready, 0);
    tick();
    clr_start = 1'b0;
    clr_value = 8'h99;

    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    rdy_bad = 0;
    for (int i = 0; i < 5000; i++) begin
      if (!clr_busy) break;
      busy_n++;
      if (clr_done) begin
        done_n++;
        done_at = busy_n;
      end
      if (wr_ready) rdy_bad++;
      clr_start = (busy_n == 100);
      tick();
    end
    clr_start = 1'b0;
    check("clr_busy_len", busy_n, 4097);
    check("clr_done_cnt", done_n, 1);
    check("clr_done_last", done_at, 4097);
    check("ready_in_clr", rdy_bad, 0);
    check("ready_first_idle", wr_ready, 1);
    fill(0, DEPTH, 8'h3C);
    tick();
    wr_valid = 1'b0;
    model[12'h055] = 8'hFF;

    flag = 0;
    repeat (10) begin
      if (clr_busy) flag = 1;
      tick();
    end
    check("no_requeue", flag, 0);

    rw("fill_000", 12'h000, 1'b0, 12'h000, 8'h00);
    rw("fill_7ff", 12'h7FF, 1'b0, 12'h000, 8'h00);
    rw("fill_fff", 12'hFFF, 1'b0, 12'h000, 8'h00);
    rw("held_wr_055", 12'h055, 1'b0, 12'h000, 8'h00);
    for (int i = 0; i < 64; i++) begin
      rw("fill_rand", AW'($urandom), 1'b0, 12'h000, 8'h00);
    end

    // Abort a clear with reset once the counter reaches 0x800.
    rw("prep_800", 12'h000, 1'b1, 12'h800, 8'h5A);
    rw("prep_7ff", 12'h000, 1'b1, 12'h7FF, 8'h00);
    clr_value = 8'hC3;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    clr_value = 8'h00;
    repeat (12'h800) tick();
    check("busy_pre_abort", clr_busy, 1);
    reset = 1'b0;
    #1;
    check("abort_rd_data", rd_data, 0);
    check("abort_clr_busy", clr_busy, 0);
    check("abort_clr_done", clr_done, 0);
    flag = 0;
    repeat (3) begin
      if (clr_done || clr_busy) flag = 1;
      tick();
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("ready_after_abort", wr_ready, 1);
    tick();
    repeat (5) begin
      if (clr_done || clr_busy) flag = 1;
      tick();
    end
    check("abort_no_done", flag, 0);
    fill(0, 12'h800, 8'hC3);
    rw("part_000", 12'h000, 1'b0, 12'h000, 8'h00);
    rw("part_7ff", 12'h7FF, 1'b0, 12'h000, 8'h00);
    rw("kept_800", 12'h800, 1'b0, 12'h000, 8'h00);
    rw("kept_801", 12'h801, 1'b0, 12'h000, 8'h00);
    for (int i = 0; i < 32; i++) begin
      rw("part_rand", AW'($urandom), 1'b0, 12'h000, 8'h00);
    end
`else
    // Without the clear engine, clear inputs are inert and writes always go through.
    clr_start = 1'b1;
    clr_value = 8'h3C;
    wr_valid  = 1'b1;
    wr_addr   = 12'h055;
    wr_data   = 8'hFF;
    #1;
    check("ready_no_clr", wr_ready, 1);
    check("busy_no_clr", clr_busy, 0);
    tick();
    wr_valid = 1'b0;
    model[12'h055] = 8'hFF;
    known[12'h055] = 1'b1;
    flag = 0;
    repeat (20) begin
      clr_start = 1'($urandom_range(0, 1));
      #1;
      if (clr_busy || clr_done || !wr_ready) flag = 1;
      tick();
    end
    check("clr_inert", flag, 0);
    rw("wr_055", 12'h055, 1'b0, 12'h000, 8'h00);
    a = 12'h123;
    rw("rd_123_again", a, 1'b0, 12'h000, 8'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vram_ctrl.md
VRAM_CTRL -- requirements
Module: vram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning the pixel address width; DEPTH = 2**ADDR_W = 4096 bytes.
REQ-002 SHALL have parameter DATA_W, default 8, meaning the grey-level pixel width.
REQ-003 SHALL have port clock  in  1  meaning the single clock for all logic; one clock, no other clock domains.
REQ-004 SHALL have port reset  in  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL have port rd_addr  in  ADDR_W  meaning the display read address, driven by the VGA address generator.
REQ-006 SHALL have port rd_data  out  DATA_W  meaning the pixel byte consumed by the VGA stage.
REQ-007 SHALL have port wr_valid  in  1  meaning the GPU write request.
REQ-008 SHALL have port wr_ready  out  1  meaning the write can be accepted this cycle.
REQ-009 SHALL have port wr_addr  in  ADDR_W  meaning the write address.
REQ-010 SHALL have port wr_data  in  DATA_W  meaning the write pixel.
REQ-011 SHALL have port clr_start  in  1  meaning a single-cycle request to fill the whole frame.
REQ-012 SHALL have port clr_value  in  DATA_W  meaning the fill pixel value.
REQ-013 SHALL have port clr_busy  out  1  meaning the clear engine is active.
REQ-014 SHALL have port clr_done  out  1  meaning a one-cycle pulse when the clear completes.

Function
REQ-015 Read port SHALL register data: rd_data = mem[rd_addr sampled at edge N], valid after edge N+1; this 1-cycle latency is fixed.
REQ-016 Read port SHALL never stall; a read is serviced every cycle regardless of write or clear activity.
REQ-017 Same-address read and write in one cycle SHALL return the old data (read-before-write).
REQ-018 A write SHALL be accepted on an edge where wr_valid && wr_ready; mem[wr_addr] is updated at that edge.
REQ-019 wr_ready SHALL be combinational: 1 iff state==IDLE && !clr_start.
REQ-020 The FSM SHALL have states IDLE, CLEAR and DONE.
REQ-021 IDLE->CLEAR on clr_start; the counter is set to 0 and clr_value is latched.
REQ-022 In CLEAR, the FSM SHALL write the latched value to mem[counter] each cycle and increment the counter.
REQ-023 At counter==DEPTH-1 the FSM SHALL perform that write and then go CLEAR->DONE; the counter SHALL NOT wrap into a second pass.
REQ-024 DONE->IDLE unconditionally after one cycle.
REQ-025 clr_busy SHALL be 1 in CLEAR and DONE; clr_done SHALL be 1 only in DONE.
REQ-026 A clear SHALL take exactly DEPTH CLEAR cycles, i.e. 4096.
REQ-027 clr_start while not in IDLE SHALL be ignored and SHALL NOT be queued.
REQ-028 When clr_start and wr_valid are both asserted in IDLE, the clear SHALL win and the write SHALL NOT be accepted; the producer must hold it.
REQ-029 A change of clr_value during a clear SHALL have no effect on that clear.

Reset
REQ-030 On reset low, the block SHALL immediately set state=IDLE, counter=0, rd_data=0, clr_busy=0 and clr_done=0.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 Reset mid-clear SHALL abort the clear with the frame left partially filled, and SHALL produce no clr_done pulse.
REQ-033 After reset release, wr_ready SHALL be 1 on the first cycle, provided clr_start is low.

Configuration
REQ-034 The macro VRAM_CLEAR_EN SHALL compile in the clear engine.
REQ-035 With VRAM_CLEAR_EN defined, behaviour SHALL be as in REQ-019 to REQ-029.
REQ-036 Without VRAM_CLEAR_EN:
- no FSM or counter is built;
- clr_start and clr_value are ignored;
- clr_busy=0 and clr_done=0 constantly;
- wr_ready=1 constantly.

Structure
REQ-037 Package vram_pkg SHALL hold the ADDR_W and DATA_W defaults and the FSM state typedef (IDLE, CLEAR, DONE).
REQ-038 Storage SHALL be the sub-module vram_dp: a simple dual-port RAM with one write port and one registered read port, with no reset on the array; vram_ctrl muxes GPU and clear writes onto its write port.

Verification
REQ-039 Reset, then write 0xA5 at 0x123, then read 0x123: rd_data=0xA5 exactly one edge after the address is sampled.
REQ-040 Write 0x11 and read the same address 0x200 in one cycle: rd_data=old value; the next read returns 0x11.
REQ-041 clr_start with clr_value=0x3C: clr_busy high for 4097 cycles and a single clr_done pulse; afterwards addresses 0x000, 0x7FF and 0xFFF read 0x3C.
REQ-042 wr_valid held during a clear: wr_ready=0 throughout; the write is accepted on the first IDLE cycle and overwrites the 0x3C fill.
REQ-043 clr_start and wr_valid (0x055 <- 0xFF) in the same cycle: the write is not accepted that cycle; a second clr_start mid-clear changes nothing.
REQ-044 Assert reset at counter 0x800: outputs go to 0 immediately and there is no clr_done; 0x7FF reads the fill value and 0x800 keeps its prior content.
